// File: rtl/gabor_win_pkg.sv
// Shared types for the 45-degree Gabor window path: kernel geometry and pixel/window typedefs
// used by window_gen_5x5 and the convolution top-level.
package gabor_win_pkg;

  localparam int KERNEL_SIZE = 5;
  localparam int WIN_PIXELS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PIXEL_W     = 9;

  typedef logic signed [PIXEL_W-1:0] pixel_t;
  typedef pixel_t [WIN_PIXELS-1:0]   window_t;

endpackage

// File: rtl/window_gen_5x5_if.sv
// Window bus between window_gen_5x5 (master/producer) and the convolution block (slave/consumer).
// WINDOW_SIDEBAND_EN adds the out_sof/out_eol flags travelling with each window.
interface window_gen_5x5_if
  import gabor_win_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_W
);

  logic                              out_valid;
  logic                              out_ready;
  logic [WIN_PIXELS*PIXEL_WIDTH-1:0] out_win;
`ifdef WINDOW_SIDEBAND_EN
  logic                              out_sof;
  logic                              out_eol;

  modport master (output out_valid, output out_win, output out_sof, output out_eol, input out_ready);
  modport slave  (input out_valid, input out_win, input out_sof, input out_eol, output out_ready);
`else
  modport master (output out_valid, output out_win, input out_ready);
  modport slave  (input out_valid, input out_win, output out_ready);
`endif

endinterface

// File: rtl/window_gen_5x5_line_buffer.sv
// One image line of storage: single-port RAM, combinational read of the old word and write
// of the new one at the same address, so a read-before-write cascade falls out naturally.
module line_buffer #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 516,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [AW-1:0]           addr,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/window_gen_5x5.sv
// Streaming 5x5 window generator: four cascaded line buffers plus a column shift register,
// emitting row-major windows. Define WINDOW_SIDEBAND_EN to add out_sof/out_eol.
module window_gen_5x5
  import gabor_win_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_W,
  parameter int IMG_WIDTH   = 516,
  parameter int IMG_HEIGHT  = 516,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [PIXEL_WIDTH-1:0] in_pixel,
  window_gen_5x5_if.master              win,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);

  if (KERNEL_SIZE != gabor_win_pkg::KERNEL_SIZE) begin : g_bad_kernel
    $error("window_gen_5x5: KERNEL_SIZE must be 5");
  end
  if (IMG_WIDTH < 5 || IMG_HEIGHT < 5) begin : g_bad_size
    $error("window_gen_5x5: image must be at least 5x5");
  end

  typedef logic signed [PIXEL_WIDTH-1:0] pix_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          acc;
  logic          col_last;
  logic          row_last;
  logic          emit;
  pix_t          lb_din [4];
  pix_t          lb_q   [4];
  pix_t          col_new [5];
  // Only the four older columns are stored; the fifth is the incoming column itself.
  pix_t          sr_p0  [5][4];
  logic [WIN_PIXELS*PIXEL_WIDTH-1:0] win_nxt;

  assign in_ready = !win.out_valid || win.out_ready;
  assign acc      = in_valid && in_ready && !clr;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign emit     = acc && (row >= ROW_FIRST) && (col >= COL_FIRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line-buffer cascade: lb_q[k] is the pixel k+1 lines above the incoming one.
  assign lb_din[0] = in_pixel;
  assign lb_din[1] = lb_q[0];
  assign lb_din[2] = lb_q[1];
  assign lb_din[3] = lb_q[2];

  for (genvar k = 0; k < 4; k++) begin : g_lb
    line_buffer #(
      .WIDTH (PIXEL_WIDTH),
      .DEPTH (IMG_WIDTH),
      .AW    (CW)
    ) u_lb (
      .clk  (clk),
      .en   (acc),
      .addr (col),
      .din  (lb_din[k]),
      .dout (lb_q[k])
    );
  end

  assign col_new[0] = lb_q[3];
  assign col_new[1] = lb_q[2];
  assign col_new[2] = lb_q[1];
  assign col_new[3] = lb_q[0];
  assign col_new[4] = in_pixel;

  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        win_nxt[(i*5+j)*PIXEL_WIDTH +: PIXEL_WIDTH] = sr_p0[i][j];
      end
      win_nxt[(i*5+4)*PIXEL_WIDTH +: PIXEL_WIDTH] = col_new[i];
    end
  end

  // Stage p0: column shift register, advances on every accept
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 3; j++) begin
          sr_p0[i][j] <= sr_p0[i][j+1];
        end
        sr_p0[i][3] <= col_new[i];
      end
    end
  end

  // Output register stage: window is held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win.out_valid <= 1'b0;
      win.out_win   <= '0;
      frame_done    <= 1'b0;
`ifdef WINDOW_SIDEBAND_EN
      win.out_sof   <= 1'b0;
      win.out_eol   <= 1'b0;
`endif
    end else begin
      frame_done <= acc && col_last && row_last;
      if (clr) begin
        win.out_valid <= 1'b0;
      end else if (in_ready) begin
        win.out_valid <= emit;
      end
      if (emit) begin
        win.out_win <= win_nxt;
`ifdef WINDOW_SIDEBAND_EN
        win.out_sof <= (row == ROW_FIRST) && (col == COL_FIRST);
        win.out_eol <= col_last;
`endif
      end
    end
  end

endmodule

// File: tb/tb_window_gen_5x5.sv
// Directed bench for window_gen_5x5 on an 8x6 ramp frame (pixel = row*16 + col).
module tb_window_gen_5x5;

  localparam int PW   = 9;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int WPR  = W - 4;
  localparam int WB   = 25 * PW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clr;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_pixel;
  logic                 frame_done;
  int                   total = 0;
  int                   bad   = 0;
  int                   fd_count;

  always #5 clk = ~clk;

  window_gen_5x5_if #(.PIXEL_WIDTH(PW)) wif ();

  window_gen_5x5 #(
    .PIXEL_WIDTH (PW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .KERNEL_SIZE (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .win        (wif),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pix_at(input int idx);
    return (idx / W) * 16 + (idx % W);
  endfunction

  function automatic logic [WB-1:0] exp_win(input int n);
    int r;
    int c;
    logic [WB-1:0] w;
    r = 4 + n / WPR;
    c = 4 + n % WPR;
    w = '0;
    for (int k = 0; k < 25; k++) w[k*PW +: PW] = PW'((r - 4 + k / 5) * 16 + (c - 4 + k % 5));
    return w;
  endfunction

  function automatic int exp_nwin(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) if ((i / W) >= 4 && (i % W) >= 4) cnt++;
    return cnt;
  endfunction

  task automatic run_frame(input bit stall, input int stop_at);
    int            pix;
    int            nwin;
    int            budget;
    bit            first;
    bit            was_stall;
    bit            acc;
    logic [WB-1:0] held;
    logic [WB-1:0] last;
    pix = 0; nwin = 0; budget = 0; first = 0; was_stall = 0;
    held = '0; last = '0; fd_count = 0;
    clr = 1'b0;
    while ((pix < stop_at || wif.out_valid) && budget < 4000) begin
      budget++;
      in_valid      = (pix < stop_at);
      in_pixel      = PW'(pix_at(pix));
      wif.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (wif.out_valid && !wif.out_ready) chk("stall_in_ready", in_ready, 0);
      if (was_stall) begin
        chk("hold_valid", wif.out_valid, 1);
        chk("hold_win", wif.out_win, held);
      end
      if (wif.out_valid && wif.out_ready) begin
        chk("win", wif.out_win, exp_win(nwin));
`ifdef WINDOW_SIDEBAND_EN
        chk("sof", wif.out_sof, nwin == 0);
        chk("eol", wif.out_eol, (nwin % WPR) == WPR - 1);
`endif
        last = wif.out_win;
        nwin++;
      end
      acc       = in_valid && in_ready;
      was_stall = wif.out_valid && !wif.out_ready;
      held      = wif.out_win;
      @(posedge clk);
      #1;
      if (acc) pix++;
      if (frame_done) begin
        fd_count++;
        chk("fd_at_last_pixel", pix, NPIX);
        chk("fd_with_valid", wif.out_valid, 1);
      end
      if (wif.out_valid && !first) begin
        first = 1;
        chk("first_latency", pix, 37);
        chk("first_p1", wif.out_win[0*PW +: PW], 0);
        chk("first_p13", wif.out_win[12*PW +: PW], 34);
        chk("first_p25", wif.out_win[24*PW +: PW], 68);
      end
    end
    in_valid      = 1'b0;
    wif.out_ready = 1'b1;
    if (budget >= 4000) chk("timeout", budget, 0);
    chk("win_count", nwin, exp_nwin(stop_at));
    chk("fd_count", fd_count, stop_at == NPIX);
    if (stop_at == NPIX) chk("last_p25", last[24*PW +: PW], 87);
  endtask

  initial begin
    rst_n         = 1'b0;
    clr           = 1'b0;
    in_valid      = 1'b0;
    in_pixel      = '0;
    wif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", wif.out_valid, 0);
    chk("rst_out_win", wif.out_win, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(1'b0, NPIX);
    run_frame(1'b1, NPIX);
    run_frame(1'b0, NPIX);
    run_frame(1'b0, NPIX);

    // Abort at row 3, col 2; the presented pixel is dropped.
    run_frame(1'b0, 3 * W + 2);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_pixel = PW'(pix_at(3 * W + 2));
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", wif.out_valid, 0);
    chk("clr_frame_done", frame_done, 0);
    chk("clr_in_ready", in_ready, 1);
    run_frame(1'b0, NPIX);

    // Asynchronous reset while the first window is being presented.
    run_frame(1'b0, 36);
    in_valid = 1'b1;
    in_pixel = PW'(pix_at(36));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", wif.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", wif.out_valid, 0);
    chk("arst_out_win", wif.out_win, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(1'b0, NPIX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
